// File: rtl/udp_reply_pkg.sv
// Shared encodings and defaults for the UDP reply framer.
// The UDP_REPLY_FRAMER_STATS_EN option lives in udp_reply_framer.sv.
package udp_reply_pkg;

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_HDR   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
   localparam logic [15:0] DEF_LOCAL_PORT = 16'd1234;
   localparam logic [7:0]  DEF_IP_TTL     = 8'd64;

   typedef struct packed {
      logic [31:0] ip;
      logic [15:0] port;
   } peer_t;

endpackage

// File: rtl/reply_byte_buffer.sv
// Simple dual-port byte RAM for one reply payload.
// The read address is registered, so data for an address appears one cycle later.
module reply_byte_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rd_addr;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      r_rd_addr <= i_rd_addr;
   end

   assign o_rd_data = r_mem[r_rd_addr];

endmodule

// File: rtl/udp_reply_framer.sv
// Buffers one reply payload, then emits the TX UDP header followed by the payload.
// Define UDP_REPLY_FRAMER_STATS_EN to add the o_tx_frames / o_drop_frames counters.
//
// state   | meaning
// S_FILL  | accepting payload bytes into the buffer
// S_HDR   | presenting the TX UDP header, waiting for the stack
// S_DRAIN | replaying the buffered payload to the stack
module udp_reply_framer
   import udp_reply_pkg::*;
#(
   parameter int          BUF_DEPTH  = 16,
   parameter logic [15:0] LOCAL_PORT = DEF_LOCAL_PORT,
   parameter logic [7:0]  IP_TTL     = DEF_IP_TTL
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx_udp_hdr_valid,
   input  logic        i_rx_udp_hdr_ready,
   input  logic [31:0] i_rx_ip_source_ip,
   input  logic [15:0] i_rx_udp_source_port,
   input  logic [7:0]  i_s_axis_tdata,
   input  logic        i_s_axis_tvalid,
   input  logic        i_s_axis_tlast,
   output logic        o_s_axis_tready,
   output logic        o_tx_udp_hdr_valid,
   input  logic        i_tx_udp_hdr_ready,
   output logic [31:0] o_tx_ip_dest_ip,
   output logic [15:0] o_tx_udp_source_port,
   output logic [15:0] o_tx_udp_dest_port,
   output logic [15:0] o_tx_udp_length,
   output logic [7:0]  o_tx_ip_ttl,
`ifdef UDP_REPLY_FRAMER_STATS_EN
   output logic [15:0] o_tx_frames,
   output logic [15:0] o_drop_frames,
`endif
   output logic [7:0]  o_m_axis_tdata,
   output logic        o_m_axis_tvalid,
   output logic        o_m_axis_tlast,
   input  logic        i_m_axis_tready
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;

   logic [1:0]    r_state;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_drop;
   peer_t         r_peer;
   peer_t         r_dest;
   logic          r_s_tready;
   logic          r_hdr_valid;
   logic [15:0]   r_len;
   logic [7:0]    r_m_tdata;
   logic          r_m_tvalid;
   logic          r_m_tlast;

   logic          w_s_acc;
   logic          w_ovf;
   logic          w_store;
   logic          w_drop_now;
   logic          w_hdr_acc;
   logic          w_m_acc;
   logic          w_load;
   logic          w_last_idx;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [7:0]    w_rd_data;

   assign w_s_acc    = i_s_axis_tvalid && r_s_tready && (r_state == S_FILL);
   assign w_ovf      = (r_cnt == CW'(BUF_DEPTH));
   assign w_store    = w_s_acc && !w_ovf;
   assign w_drop_now = r_drop || w_ovf;
   assign w_hdr_acc  = r_hdr_valid && i_tx_udp_hdr_ready;
   assign w_m_acc    = r_m_tvalid && i_m_axis_tready;
   assign w_load     = ((r_state == S_HDR) && w_hdr_acc) ||
                       ((r_state == S_DRAIN) && w_m_acc && !r_m_tlast);
   assign w_last_idx = ({1'b0, r_rd_ptr} == (r_cnt - CW'(1)));

   // r_rd_ptr names the next byte to load into the output register; the RAM
   // address register tracks it so w_rd_data is always that byte (pre-fetch).
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr;
      if (i_rst)
         w_rd_ptr_nxt = '0;
      else if ((r_state == S_DRAIN) && w_m_acc && r_m_tlast)
         w_rd_ptr_nxt = '0;
      else if (w_load)
         w_rd_ptr_nxt = r_rd_ptr + AW'(1);
   end

   reply_byte_buffer #(
      .DEPTH (BUF_DEPTH),
      .AW    (AW)
   ) u_buf (
      .i_clk     (i_clk),
      .i_wr_en   (w_store),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_s_axis_tdata),
      .i_rd_addr (w_rd_ptr_nxt),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_peer <= '0;
      end else if (i_rx_udp_hdr_valid && i_rx_udp_hdr_ready) begin
         r_peer.ip   <= i_rx_ip_source_ip;
         r_peer.port <= i_rx_udp_source_port;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_FILL;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_drop      <= 1'b0;
         r_dest      <= '0;
         r_s_tready  <= 1'b0;
         r_hdr_valid <= 1'b0;
         r_len       <= '0;
         r_m_tdata   <= '0;
         r_m_tvalid  <= 1'b0;
         r_m_tlast   <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         case (r_state)
            S_FILL: begin
               r_s_tready <= 1'b1;
               if (w_store) begin
                  r_wr_ptr <= r_wr_ptr + AW'(1);
                  r_cnt    <= r_cnt + CW'(1);
                  if (r_cnt == '0) r_dest <= r_peer;
               end else if (w_s_acc) begin
                  r_drop <= 1'b1;
               end
               if (w_s_acc && i_s_axis_tlast) begin
                  if (w_drop_now) begin
                     r_cnt    <= '0;
                     r_wr_ptr <= '0;
                     r_drop   <= 1'b0;
                  end else begin
                     r_s_tready  <= 1'b0;
                     r_hdr_valid <= 1'b1;
                     r_len       <= UDP_HDR_LEN + 16'(r_cnt) + 16'd1;
                     r_state     <= S_HDR;
                  end
               end
            end
            S_HDR: begin
               if (w_hdr_acc) begin
                  r_hdr_valid <= 1'b0;
                  r_m_tvalid  <= 1'b1;
                  r_m_tdata   <= w_rd_data;
                  r_m_tlast   <= w_last_idx;
                  r_state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_m_acc) begin
                  if (r_m_tlast) begin
                     r_m_tvalid <= 1'b0;
                     r_m_tlast  <= 1'b0;
                     r_cnt      <= '0;
                     r_wr_ptr   <= '0;
                     r_s_tready <= 1'b1;
                     r_state    <= S_FILL;
                  end else begin
                     r_m_tdata <= w_rd_data;
                     r_m_tlast <= w_last_idx;
                  end
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

`ifdef UDP_REPLY_FRAMER_STATS_EN
   logic [15:0] r_tx_frames;
   logic [15:0] r_drop_frames;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_frames   <= '0;
         r_drop_frames <= '0;
      end else begin
         if ((r_state == S_HDR) && w_hdr_acc)
            r_tx_frames <= r_tx_frames + 16'd1;
         if (w_s_acc && i_s_axis_tlast && w_drop_now)
            r_drop_frames <= r_drop_frames + 16'd1;
      end
   end

   assign o_tx_frames   = r_tx_frames;
   assign o_drop_frames = r_drop_frames;
`endif

   assign o_s_axis_tready      = r_s_tready;
   assign o_tx_udp_hdr_valid   = r_hdr_valid;
   assign o_tx_ip_dest_ip      = r_dest.ip;
   assign o_tx_udp_dest_port   = r_dest.port;
   assign o_tx_udp_source_port = LOCAL_PORT;
   assign o_tx_udp_length      = r_len;
   assign o_tx_ip_ttl          = IP_TTL;
   assign o_m_axis_tdata       = r_m_tdata;
   assign o_m_axis_tvalid      = r_m_tvalid;
   assign o_m_axis_tlast       = r_m_tlast;

endmodule

// File: tb/tb_udp_reply_framer.sv
// Self-checking bench for udp_reply_framer: directed cases plus randomized frames
// compared against a frame-level model (peer capture, length, drop, payload order).
`timescale 1ns/1ps
module tb_udp_reply_framer;

   localparam int BUF_DEPTH = 16;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_rx_udp_hdr_valid;
   logic        i_rx_udp_hdr_ready;
   logic [31:0] i_rx_ip_source_ip;
   logic [15:0] i_rx_udp_source_port;
   logic [7:0]  i_s_axis_tdata;
   logic        i_s_axis_tvalid;
   logic        i_s_axis_tlast;
   logic        o_s_axis_tready;
   logic        o_tx_udp_hdr_valid;
   logic        i_tx_udp_hdr_ready;
   logic [31:0] o_tx_ip_dest_ip;
   logic [15:0] o_tx_udp_source_port;
   logic [15:0] o_tx_udp_dest_port;
   logic [15:0] o_tx_udp_length;
   logic [7:0]  o_tx_ip_ttl;
`ifdef UDP_REPLY_FRAMER_STATS_EN
   logic [15:0] o_tx_frames;
   logic [15:0] o_drop_frames;
`endif
   logic [7:0]  o_m_axis_tdata;
   logic        o_m_axis_tvalid;
   logic        o_m_axis_tlast;
   logic        i_m_axis_tready;

   udp_reply_framer #(
      .BUF_DEPTH  (BUF_DEPTH),
      .LOCAL_PORT (16'd1234),
      .IP_TTL     (8'd64)
   ) dut (
      .i_clk                (i_clk),
      .i_rst                (i_rst),
      .i_rx_udp_hdr_valid   (i_rx_udp_hdr_valid),
      .i_rx_udp_hdr_ready   (i_rx_udp_hdr_ready),
      .i_rx_ip_source_ip    (i_rx_ip_source_ip),
      .i_rx_udp_source_port (i_rx_udp_source_port),
      .i_s_axis_tdata       (i_s_axis_tdata),
      .i_s_axis_tvalid      (i_s_axis_tvalid),
      .i_s_axis_tlast       (i_s_axis_tlast),
      .o_s_axis_tready      (o_s_axis_tready),
      .o_tx_udp_hdr_valid   (o_tx_udp_hdr_valid),
      .i_tx_udp_hdr_ready   (i_tx_udp_hdr_ready),
      .o_tx_ip_dest_ip      (o_tx_ip_dest_ip),
      .o_tx_udp_source_port (o_tx_udp_source_port),
      .o_tx_udp_dest_port   (o_tx_udp_dest_port),
      .o_tx_udp_length      (o_tx_udp_length),
      .o_tx_ip_ttl          (o_tx_ip_ttl),
`ifdef UDP_REPLY_FRAMER_STATS_EN
      .o_tx_frames          (o_tx_frames),
      .o_drop_frames        (o_drop_frames),
`endif
      .o_m_axis_tdata       (o_m_axis_tdata),
      .o_m_axis_tvalid      (o_m_axis_tvalid),
      .o_m_axis_tlast       (o_m_axis_tlast),
      .i_m_axis_tready      (i_m_axis_tready)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   logic [31:0] m_peer_ip;
   logic [15:0] m_peer_port;
   logic [31:0] exp_ip;
   logic [15:0] exp_port;
   int          m_tx_frames;
   int          m_drop_frames;
   logic [7:0]  frame_q[$];
   logic [31:0] nx_ip;
   logic [15:0] nx_port;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic rx_pulse(input logic [31:0] ip, input logic [15:0] port,
                           input logic v, input logic r);
      i_rx_ip_source_ip    = ip;
      i_rx_udp_source_port = port;
      i_rx_udp_hdr_valid   = v;
      i_rx_udp_hdr_ready   = r;
      step();
      i_rx_udp_hdr_valid = 1'b0;
      i_rx_udp_hdr_ready = 1'b0;
      if (v && r) begin
         m_peer_ip   = ip;
         m_peer_port = port;
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      i_s_axis_tdata  = d;
      i_s_axis_tvalid = 1'b1;
      i_s_axis_tlast  = l;
      while (!o_s_axis_tready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("s_tready_timeout", o_s_axis_tready, 1);
      step();
      i_s_axis_tvalid = 1'b0;
      i_s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < frame_q.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         if (i == 0) begin
            exp_ip   = m_peer_ip;
            exp_port = m_peer_port;
         end
         push_byte(frame_q[i], i == frame_q.size() - 1);
      end
   endtask

   task automatic check_stats();
`ifdef UDP_REPLY_FRAMER_STATS_EN
      chk("tx_frames", o_tx_frames, 16'(m_tx_frames));
      chk("drop_frames", o_drop_frames, 16'(m_drop_frames));
`endif
   endtask

   // mode 0: sink always ready, 1: ready toggles 1010..., 2: random ready
   task automatic check_frame(input int hold, input int mode, input int rx_beat);
      int len;
      int got;
      int cyc;
      len = frame_q.size();
      if (len > BUF_DEPTH) begin
         m_drop_frames++;
         repeat (4) begin
            chk("drop_no_hdr", o_tx_udp_hdr_valid, 0);
            chk("drop_s_tready", o_s_axis_tready, 1);
            step();
         end
         check_stats();
         return;
      end
      chk("hdr_latency", o_tx_udp_hdr_valid, 1);
      for (int k = 0; k < hold; k++) begin
         i_tx_udp_hdr_ready = 1'b0;
         chk("hold_valid", o_tx_udp_hdr_valid, 1);
         chk("hold_dest_ip", o_tx_ip_dest_ip, exp_ip);
         chk("hold_dest_port", o_tx_udp_dest_port, exp_port);
         chk("hold_length", o_tx_udp_length, 16'(8 + len));
         chk("hold_m_tvalid", o_m_axis_tvalid, 0);
         chk("hold_s_tready", o_s_axis_tready, 0);
         step();
      end
      i_tx_udp_hdr_ready = 1'b1;
      chk("hdr_valid", o_tx_udp_hdr_valid, 1);
      chk("hdr_dest_ip", o_tx_ip_dest_ip, exp_ip);
      chk("hdr_dest_port", o_tx_udp_dest_port, exp_port);
      chk("hdr_length", o_tx_udp_length, 16'(8 + len));
      chk("hdr_src_port", o_tx_udp_source_port, 16'd1234);
      chk("hdr_ttl", o_tx_ip_ttl, 8'd64);
      chk("pre_hs_m_tvalid", o_m_axis_tvalid, 0);
      step();
      i_tx_udp_hdr_ready = 1'b0;
      m_tx_frames++;
      chk("first_beat_latency", o_m_axis_tvalid, 1);
      chk("hdr_dropped", o_tx_udp_hdr_valid, 0);
      got = 0;
      cyc = 0;
      while (got < len && cyc < 400) begin
         case (mode)
            0:       i_m_axis_tready = 1'b1;
            1:       i_m_axis_tready = (cyc % 2 == 0);
            default: i_m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         if (cyc == rx_beat) begin
            i_rx_ip_source_ip    = nx_ip;
            i_rx_udp_source_port = nx_port;
            i_rx_udp_hdr_valid   = 1'b1;
            i_rx_udp_hdr_ready   = 1'b1;
         end
         chk("drain_s_tready", o_s_axis_tready, 0);
         if (o_m_axis_tvalid && i_m_axis_tready) begin
            chk("drain_data", o_m_axis_tdata, frame_q[got]);
            chk("drain_tlast", o_m_axis_tlast, got == len - 1);
            got++;
         end
         step();
         if (cyc == rx_beat) begin
            i_rx_udp_hdr_valid = 1'b0;
            i_rx_udp_hdr_ready = 1'b0;
            m_peer_ip   = nx_ip;
            m_peer_port = nx_port;
         end
         cyc++;
      end
      if (got < len) chk("drain_timeout", got, len);
      i_m_axis_tready = 1'b0;
      chk("post_m_tvalid", o_m_axis_tvalid, 0);
      chk("post_s_tready", o_s_axis_tready, 1);
      check_stats();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_tready"}, o_s_axis_tready, 0);
      chk({tag, "_hdr_valid"}, o_tx_udp_hdr_valid, 0);
      chk({tag, "_dest_ip"}, o_tx_ip_dest_ip, 0);
      chk({tag, "_dest_port"}, o_tx_udp_dest_port, 0);
      chk({tag, "_length"}, o_tx_udp_length, 0);
      chk({tag, "_src_port"}, o_tx_udp_source_port, 16'd1234);
      chk({tag, "_ttl"}, o_tx_ip_ttl, 8'd64);
      chk({tag, "_m_tdata"}, o_m_axis_tdata, 0);
      chk({tag, "_m_tvalid"}, o_m_axis_tvalid, 0);
      chk({tag, "_m_tlast"}, o_m_axis_tlast, 0);
`ifdef UDP_REPLY_FRAMER_STATS_EN
      chk({tag, "_tx_frames"}, o_tx_frames, 0);
      chk({tag, "_drop_frames"}, o_drop_frames, 0);
`endif
   endtask

   initial begin
      i_rst = 1'b1;
      i_rx_udp_hdr_valid = 1'b0;
      i_rx_udp_hdr_ready = 1'b0;
      i_rx_ip_source_ip = '0;
      i_rx_udp_source_port = '0;
      i_s_axis_tdata = '0;
      i_s_axis_tvalid = 1'b0;
      i_s_axis_tlast = 1'b0;
      i_tx_udp_hdr_ready = 1'b0;
      i_m_axis_tready = 1'b0;
      m_peer_ip = '0;
      m_peer_port = '0;
      m_tx_frames = 0;
      m_drop_frames = 0;
      nx_ip = '0;
      nx_port = '0;
      repeat (3) step();
      check_reset_outputs("reset");
      i_rst = 1'b0;

      // basic reply, then header held off 10 cycles, then toggling sink
      rx_pulse(32'hC0A8_0180, 16'd5000, 1'b1, 1'b1);
      for (int t = 0; t < 3; t++) begin
         frame_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
         send_frame(1'b0);
         check_frame(t == 1 ? 10 : 0, t == 2 ? 1 : 0, -1);
      end

      // snooped header without ready must not move the peer
      rx_pulse(32'h0101_0101, 16'd99, 1'b1, 1'b0);
      frame_q = '{8'h11, 8'h22};
      send_frame(1'b0);
      check_frame(0, 0, -1);

      // overflow drop, then single byte, then exactly full buffer
      frame_q = {};
      for (int i = 0; i < 17; i++) frame_q.push_back(8'(i + 8'h30));
      send_frame(1'b0);
      check_frame(0, 0, -1);
      frame_q = '{8'h55};
      send_frame(1'b0);
      check_frame(0, 0, -1);
      frame_q = {};
      for (int i = 0; i < BUF_DEPTH; i++) frame_q.push_back(8'(8'hA0 + i));
      send_frame(1'b1);
      check_frame(2, 2, -1);

      // peer update during drain affects only the next frame
      nx_ip = 32'h0A00_0001;
      nx_port = 16'd7;
      frame_q = '{8'hC1, 8'hC2, 8'hC3};
      send_frame(1'b0);
      check_frame(0, 0, 1);
      frame_q = '{8'h77, 8'h88};
      send_frame(1'b0);
      chk("next_dest_ip", exp_ip, 32'h0A00_0001);
      check_frame(0, 0, -1);

      // reset after two of four drain beats
      frame_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame(1'b0);
      i_tx_udp_hdr_ready = 1'b1;
      step();
      i_tx_udp_hdr_ready = 1'b0;
      i_m_axis_tready = 1'b1;
      step();
      step();
      i_m_axis_tready = 1'b0;
      i_rst = 1'b1;
      step();
      check_reset_outputs("midrst");
      i_rst = 1'b0;
      m_tx_frames = 0;
      m_drop_frames = 0;
      m_peer_ip = '0;
      m_peer_port = '0;
      i_m_axis_tready = 1'b1;
      repeat (3) begin
         chk("postrst_hdr_valid", o_tx_udp_hdr_valid, 0);
         chk("postrst_m_tvalid", o_m_axis_tvalid, 0);
         step();
      end
      i_m_axis_tready = 1'b0;
      rx_pulse(32'hC0A8_0005, 16'd4321, 1'b1, 1'b1);
      frame_q = '{8'h12, 8'h34};
      send_frame(1'b0);
      check_frame(0, 0, -1);

      // randomized frames
      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 1) == 1)
            rx_pulse($urandom, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         frame_q = {};
         for (int i = 0, n = $urandom_range(1, 20); i < n; i++)
            frame_q.push_back(8'($urandom));
         nx_ip = $urandom;
         nx_port = 16'($urandom);
         send_frame(1'($urandom_range(0, 1)));
         check_frame($urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
